// File: rtl/debouncer_bank.sv
// Bank of independent button debouncers. Each channel has an input synchronizer,
// a stability counter and registered rise/fall pulses.
module debouncer_bank #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] button_in,
    output logic [NUM_CH-1:0] button_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic              any_change
);

    localparam longint unsigned CntLimit = (64'd1 << CNT_WIDTH) - 64'd1;

    generate
        if (STABLE_CYCLES < 1 || 64'(STABLE_CYCLES) > CntLimit || SYNC_STAGES < 2)
        begin : g_param_check
            $error("debouncer_bank: illegal STABLE_CYCLES, CNT_WIDTH or SYNC_STAGES");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] CntMax   = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [NUM_CH-1:0]    SyncInit = {NUM_CH{ACTIVE_LOW}};

    logic [NUM_CH-1:0]    sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]    level_q;
    logic [NUM_CH-1:0]    out_q, out_d;
    logic [NUM_CH-1:0]    rise_q, rise_d;
    logic [NUM_CH-1:0]    fall_q, fall_d;
    logic                 any_q, any_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];

    // The polarity-corrected level gets its own flop, so a steady input reaches
    // button_out SYNC_STAGES + STABLE_CYCLES edges after it is first sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= SyncInit;
            end
            level_q <= '0;
        end else begin
            sync_q[0] <= button_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            level_q <= sync_q[SYNC_STAGES-1] ^ SyncInit;
        end
    end

    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            cnt_d[c] = cnt_q[c];
            if (level_q[c] == out_q[c]) begin
                // Matching level: either idle or a bounce, so progress is dropped.
                cnt_d[c] = '0;
            end else if (cnt_q[c] == CntMax) begin
                out_d[c]  = level_q[c];
                cnt_d[c]  = '0;
                rise_d[c] = level_q[c];
                fall_d[c] = ~level_q[c];
            end else begin
                cnt_d[c] = cnt_q[c] + CNT_WIDTH'(1);
            end
        end
        any_d = |{rise_d, fall_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= any_d;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign button_out = out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_change = any_q;

endmodule

// File: tb/tb_debouncer_bank.sv
// Bench for debouncer_bank: three configurations (baseline, active-low, one-cycle
// stability) checked every cycle against a window-based model plus fixed timings.
module tb_debouncer_bank;

    localparam int NI   = 3;
    localparam int SYNC = 2;
    localparam int MAXE = 8192;

    logic       clk = 1'b0;
    logic       rst   [NI];
    logic [1:0] bin   [NI];
    logic [1:0] bout  [NI];
    logic [1:0] rise  [NI];
    logic [1:0] fall  [NI];
    logic       anyc  [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    debouncer_bank #(
        .NUM_CH(2), .CNT_WIDTH(8), .STABLE_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0)
    ) u_main (
        .clk(clk), .reset(rst[0]), .button_in(bin[0]), .button_out(bout[0]),
        .rise_pulse(rise[0]), .fall_pulse(fall[0]), .any_change(anyc[0])
    );

    debouncer_bank #(
        .NUM_CH(2), .CNT_WIDTH(8), .STABLE_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1)
    ) u_al (
        .clk(clk), .reset(rst[1]), .button_in(bin[1]), .button_out(bout[1]),
        .rise_pulse(rise[1]), .fall_pulse(fall[1]), .any_change(anyc[1])
    );

    debouncer_bank #(
        .NUM_CH(2), .CNT_WIDTH(4), .STABLE_CYCLES(1), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0)
    ) u_fast (
        .clk(clk), .reset(rst[2]), .button_in(bin[2]), .button_out(bout[2]),
        .rise_pulse(rise[2]), .fall_pulse(fall[2]), .any_change(anyc[2])
    );

    function automatic int stab_of(input int n);
        return (n == 2) ? 1 : 4;
    endfunction

    function automatic bit al_of(input int n);
        return (n == 1);
    endfunction

    // Model: raw input history plus the edge of the last reset / accepted change.
    int       k = 0;
    bit [1:0] in_hist  [NI][MAXE];
    int       last_rst [NI];
    int       last_evt [NI][2];
    bit       valid    [NI] = '{default: 1'b0};
    bit [1:0] e_out    [NI];
    bit [1:0] e_rise   [NI];
    bit [1:0] e_fall   [NI];
    bit       e_any    [NI];

    // Level seen by the decision at edge j: raw input sampled SYNC+1 edges earlier,
    // or the cleared value if that sample predates the last reset.
    function automatic bit s_at(input int n, input int j, input int c);
        int idx;
        idx = j - SYNC - 1;
        if (idx > last_rst[n]) return in_hist[n][idx][c] ^ al_of(n);
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        k = k + 1;
        if (k < MAXE) begin
            for (int n = 0; n < NI; n++) begin
                in_hist[n][k] = bin[n];
                if (rst[n]) begin
                    valid[n]       = 1'b1;
                    last_rst[n]    = k;
                    last_evt[n][0] = k;
                    last_evt[n][1] = k;
                    e_out[n]       = 2'b00;
                    e_rise[n]      = 2'b00;
                    e_fall[n]      = 2'b00;
                    e_any[n]       = 1'b0;
                end else begin
                    e_rise[n] = 2'b00;
                    e_fall[n] = 2'b00;
                    for (int c = 0; c < 2; c++) begin
                        bit old;
                        bit flip;
                        old  = e_out[n][c];
                        flip = (k - stab_of(n) >= last_evt[n][c]);
                        for (int j = 0; j < stab_of(n); j++) begin
                            if (s_at(n, k - j, c) == old) flip = 1'b0;
                        end
                        if (flip) begin
                            e_out[n][c]    = ~old;
                            e_rise[n][c]   = ~old;
                            e_fall[n][c]   = old;
                            last_evt[n][c] = k;
                        end
                    end
                    e_any[n] = |{e_rise[n], e_fall[n]};
                end
            end
        end
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%b want=%b (edge %0d)", name, act, exp, k);
        end
    endtask

    always @(negedge clk) begin
        for (int n = 0; n < NI; n++) begin
            if (valid[n]) begin
                check($sformatf("model_out%0d", n), bout[n], e_out[n]);
                check($sformatf("model_rise%0d", n), rise[n], e_rise[n]);
                check($sformatf("model_fall%0d", n), fall[n], e_fall[n]);
                check($sformatf("model_any%0d", n), {1'b0, anyc[n]}, {1'b0, e_any[n]});
                check($sformatf("rise_and_fall%0d", n), rise[n] & fall[n], 2'b00);
            end
        end
    end

    bit [1:0] tgt [NI];
    bit       lv  [6];

    initial begin
        for (int n = 0; n < NI; n++) rst[n] = 1'b1;
        bin[0] = 2'b00;
        bin[1] = 2'b11;
        bin[2] = 2'b00;

        @(negedge clk);
        check("reset_out", bout[0], 2'b00);
        check("reset_rise", rise[0], 2'b00);
        check("reset_any_al", {1'b0, anyc[1]}, 2'b00);
        repeat (2) @(negedge clk);
        for (int n = 0; n < NI; n++) rst[n] = 1'b0;
        repeat (4) @(negedge clk);
        check("al_idle_out", bout[1], 2'b00);
        check("al_idle_rise", rise[1], 2'b00);

        // Clean press on channel 0: accepted 6 edges after the sampling edge.
        bin[0][0] = 1'b1;
        repeat (6) @(negedge clk);
        check("press_early_out", bout[0], 2'b00);
        @(negedge clk);
        check("press_out", bout[0], 2'b01);
        check("press_rise", rise[0], 2'b01);
        check("press_any", {1'b0, anyc[0]}, 2'b01);
        @(negedge clk);
        check("press_rise_once", rise[0], 2'b00);
        check("press_any_once", {1'b0, anyc[0]}, 2'b00);

        // Simultaneous: ch0 falls while ch1 rises.
        bin[0] = 2'b10;
        repeat (6) @(negedge clk);
        check("simul_early_out", bout[0], 2'b01);
        @(negedge clk);
        check("simul_out", bout[0], 2'b10);
        check("simul_fall", fall[0], 2'b01);
        check("simul_rise", rise[0], 2'b10);
        check("simul_any", {1'b0, anyc[0]}, 2'b01);
        @(negedge clk);
        check("simul_any_once", {1'b0, anyc[0]}, 2'b00);

        // Reset mid-count discards progress and generates no pulse.
        bin[0] = 2'b11;
        repeat (3) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("rst_mid_out", bout[0], 2'b00);
        check("rst_mid_fall", fall[0], 2'b00);
        check("rst_mid_rise", rise[0], 2'b00);
        repeat (6) @(negedge clk);
        check("rst_mid_hold", bout[0], 2'b00);
        @(negedge clk);
        check("rst_mid_accept", bout[0], 2'b11);
        check("rst_mid_rise_pulse", rise[0], 2'b11);

        // Bounce 1,0,1,0 for two cycles each, then hold high.
        bin[0] = 2'b00;
        repeat (12) @(negedge clk);
        check("release_out", bout[0], 2'b00);
        for (int i = 0; i < 4; i++) begin
            bin[0][0] = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        bin[0][0] = 1'b1;
        repeat (6) @(negedge clk);
        check("bounce_hold", bout[0], 2'b00);
        @(negedge clk);
        check("bounce_out", bout[0], 2'b01);
        check("bounce_rise", rise[0], 2'b01);

        // Active-low channel pressed by driving it to 0.
        bin[1][0] = 1'b0;
        repeat (6) @(negedge clk);
        check("al_early", bout[1], 2'b00);
        @(negedge clk);
        check("al_out", bout[1], 2'b01);
        check("al_rise", rise[1], 2'b01);

        // One-cycle stability: every toggle shows up 3 edges later with a pulse.
        for (int i = 0; i < 6; i++) lv[i] = (i % 2 == 0);
        for (int i = 0; i < 6; i++) begin
            bin[2][1] = lv[i];
            @(negedge clk);
            if (i > 0) begin
                check("fast_out", {bout[2][1], 1'b0}, {lv[i-1], 1'b0});
                check("fast_rise", {rise[2][1], 1'b0}, {lv[i-1], 1'b0});
                check("fast_fall", {fall[2][1], 1'b0}, {~lv[i-1], 1'b0});
            end
            repeat (2) @(negedge clk);
        end
        @(negedge clk);
        check("fast_last_out", {bout[2][1], 1'b0}, {lv[5], 1'b0});
        check("fast_last_fall", {fall[2][1], 1'b0}, {~lv[5], 1'b0});

        // Random bouncing traffic with occasional resets.
        for (int n = 0; n < NI; n++) tgt[n] = bin[n];
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int n = 0; n < NI; n++) begin
                rst[n] = ($urandom_range(0, 299) == 0);
                for (int c = 0; c < 2; c++) begin
                    if ($urandom_range(0, 39) == 0) tgt[n][c] = ~tgt[n][c];
                    bin[n][c] = ($urandom_range(0, 5) == 0) ? ~tgt[n][c] : tgt[n][c];
                end
            end
            @(negedge clk);
        end
        for (int n = 0; n < NI; n++) rst[n] = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
